// File: rtl/mem_trace_pkg.sv
// rtl/mem_trace_pkg.sv - shared types and width helpers for the memory-trace issuer
package mem_trace_pkg;

  localparam int TRACE_DATA_W = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/source_id_allocator.sv
// rtl/source_id_allocator.sv - source ID free bitmap, lowest-free grant and outstanding count
module source_id_allocator
  import mem_trace_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  localparam int SW = idx_w(NUM_SOURCES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alloc,
  input  logic [SW-1:0] alloc_id,
  input  logic          free_valid,
  input  logic [SW-1:0] free_id,
  output logic          grant_valid,
  output logic [SW-1:0] grant_id,
  output logic [SW:0]   inflight,
  output logic          err_spurious
);

  logic [NUM_SOURCES-1:0] busy;
  logic [NUM_SOURCES-1:0] busy_next;
  logic                   free_ok;

  // Grant looks only at the registered bitmap, so an ID freed this cycle waits one cycle.
  assign free_ok     = free_valid && busy[free_id];
  assign grant_valid = ~&busy;

  always_comb begin
    grant_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (!busy[i]) grant_id = i[SW-1:0];
    end
    busy_next = busy;
    if (alloc)   busy_next[alloc_id] = 1'b1;
    if (free_ok) busy_next[free_id]  = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy         <= '0;
      inflight     <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy <= busy_next;
      if (free_valid && !busy[free_id]) err_spurious <= 1'b1;
      case ({alloc, free_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_trace_issuer.sv
// rtl/mem_trace_issuer.sv - serializes per-thread trace vectors into tagged single-lane requests
module mem_trace_issuer
  import mem_trace_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_W      = 32,
  parameter int NUM_SOURCES = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic                                trace_read_ready,
  input  logic [NUM_THREADS-1:0]              trace_read_valid,
  input  logic [TRACE_DATA_W*NUM_THREADS-1:0] trace_read_address,
  input  logic                                trace_read_finished,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [ADDR_W-1:0]                   req_addr,
  output logic [idx_w(NUM_THREADS)-1:0]       req_tid,
  output logic [idx_w(NUM_SOURCES)-1:0]       req_source,
  input  logic                                resp_valid,
  input  logic [idx_w(NUM_SOURCES)-1:0]       resp_source,
  output logic [idx_w(NUM_SOURCES):0]         inflight,
  output logic                                done,
  output logic                                err_spurious
);

  localparam int TW = idx_w(NUM_THREADS);
  localparam int SW = idx_w(NUM_SOURCES);

  state_t                 state;
  logic [NUM_THREADS-1:0] pending;
  logic [ADDR_W-1:0]      addr_q [NUM_THREADS];
  logic [TW-1:0]          lane;
  logic                   hold;
  logic [SW-1:0]          held_src;
  logic                   grant_valid;
  logic [SW-1:0]          grant_id;
  logic                   fire;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^trace_read_address;

  always_comb begin
    lane = '0;
    for (int g = NUM_THREADS - 1; g >= 0; g--) begin
      if (pending[g]) lane = g[TW-1:0];
    end
  end

  // A stalled offer keeps its source even if a lower ID frees up meanwhile.
  assign req_source       = hold ? held_src : grant_id;
  assign req_valid        = (state == ISSUE) && (hold || grant_valid);
  assign req_tid          = lane;
  assign req_addr         = addr_q[lane];
  assign fire             = req_valid && req_ready;
  assign trace_read_ready = (state == IDLE);
  assign done             = (state == DONE);

  source_id_allocator #(.NUM_SOURCES(NUM_SOURCES)) u_alloc (
    .clock        (clock),
    .reset        (reset),
    .alloc        (fire),
    .alloc_id     (req_source),
    .free_valid   (resp_valid),
    .free_id      (resp_source),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .inflight     (inflight),
    .err_spurious (err_spurious)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      hold     <= 1'b0;
      held_src <= '0;
      for (int g = 0; g < NUM_THREADS; g++) addr_q[g] <= '0;
    end else begin
      hold     <= req_valid && !req_ready;
      held_src <= req_source;
      case (state)
        IDLE: begin
          if (|trace_read_valid) begin
            pending <= trace_read_valid;
            for (int g = 0; g < NUM_THREADS; g++)
              addr_q[g] <= trace_read_address[TRACE_DATA_W*g +: ADDR_W];
            state <= ISSUE;
          end else if (trace_read_finished) begin
            state <= DRAIN;
          end
        end
        ISSUE: begin
          if (fire) begin
            pending[lane] <= 1'b0;
            if ((pending & ~(NUM_THREADS'(1) << lane)) == '0) state <= IDLE;
          end
        end
        DRAIN:   if (inflight == '0) state <= DONE;
        DONE:    ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
